data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; valid byte range 0 to DEPTH_WORDS*4-1.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port Clock, input, 1: single clock; all state updates on posedge.
REQ-003 The block SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port Addr, input, 32: byte address, the EX/MEM ALU result.
REQ-005 The block SHALL have port WData, input, 32: store data, forwarded rt value.
REQ-006 The block SHALL have port MemWrite, input, 1: store request this cycle.
REQ-007 The block SHALL have port StoreType, input, 2: store width; 0 = sw, 1 = sh, 2 = sb, 3 = reserved and treated as no store.
REQ-008 The block SHALL have port LoadType, input, 3: load width; 0 = lw, 1 = lbu, 2 = lb, 3 = lhu, 4 = lh, 5-7 = lw.
REQ-009 The block SHALL have port MemRead, input, 1: load request; it qualifies AddrErr only.
REQ-010 The block SHALL have port DMOut, output, 32: extended load data, consumed by the MEM/WB register.
REQ-011 The block SHALL have port AddrErr, output, 1: misaligned or out-of-range access this cycle.

Function
REQ-012 Storage SHALL be an array of DEPTH_WORDS 32-bit words, word index Addr[log2(DEPTH_WORDS)+1:2], little-endian: byte 0 = bits [7:0].
REQ-013 Reads SHALL be combinational from current array contents, with zero cycle latency.
REQ-014 A store SHALL commit at posedge when Reset = 0, MemWrite = 1, StoreType != 3 and AddrErr = 0.
REQ-015 sw SHALL write the full word.
REQ-016 sh SHALL write halfword Addr[1] with WData[15:0] and leave the other halfword unchanged.
REQ-017 sb SHALL write byte Addr[1:0] with WData[7:0] and leave the other bytes unchanged.
REQ-018 lw SHALL return the full word.
REQ-019 lbu and lb SHALL select byte Addr[1:0]; lbu zero-extends it and lb sign-extends it from bit 7.
REQ-020 lhu and lh SHALL select halfword Addr[1]; lhu zero-extends it and lh sign-extends it from bit 15.
REQ-021 Misalignment SHALL be detected as follows: word access with Addr[1:0] != 0, or half access with Addr[0] != 0.
REQ-022 Out of range SHALL be detected as Addr >= DEPTH_WORDS*4.
REQ-023 AddrErr SHALL be 1 when (MemWrite or MemRead) is 1 and the access is misaligned or out of range; otherwise it SHALL be 0.
REQ-024 When AddrErr = 1, the store SHALL be suppressed and DMOut SHALL be 0.
REQ-025 When Addr is out of range, DMOut SHALL be 0 regardless of MemRead.
REQ-026 On a store and a load to the same word in the same cycle, DMOut SHALL show the pre-store contents, and the stored value SHALL be visible from the next cycle.
REQ-027 Back-to-back stores to the same word on consecutive cycles SHALL accumulate: sb then sb to different bytes preserves both.
REQ-028 Arithmetic SHALL be range compare only; addresses SHALL NOT wrap modulo depth.

Reset
REQ-029 At posedge with Reset = 1, every array word SHALL be cleared to 0x00000000.
REQ-030 Reset SHALL take priority over a simultaneous store, which is discarded.
REQ-031 After reset, DMOut SHALL read 0 for every address and AddrErr SHALL follow the inputs combinationally.
REQ-032 Reset asserted mid-program SHALL clear all prior stores; no partial write SHALL survive.

Verification
REQ-033 Full-word path: sw WData = 0x8765_4321 to Addr 0x10 -> next cycle, lw 0x10 SHALL return 0x87654321, lbu 0x13 SHALL return 0x00000087, lb 0x13 SHALL return 0xFFFFFF87, lh 0x12 SHALL return 0xFFFF8765, and lhu 0x10 SHALL return 0x00004321.
REQ-034 Partial stores: after word 0x20 = 0, sb 0xAB to 0x21, then sh 0xCDEF to 0x22 -> lw 0x20 SHALL return 0xCDEFAB00.
REQ-035 Misaligned accesses: sw to 0x0102 with word 0x0100 = 0x11111111 -> AddrErr = 1 that cycle and word 0x0100 unchanged; lh 0x0105 -> AddrErr = 1 and DMOut = 0.
REQ-036 Out-of-range access: with DEPTH_WORDS = 1024, sw to 0x1000 -> AddrErr = 1, no write anywhere, and lw 0x0000 unchanged.
REQ-037 Same-cycle store and load: sw 0x5A5A5A5A to 0x30 with DMOut observed combinationally that cycle -> old value 0; next cycle -> 0x5A5A5A5A.
REQ-038 Reset with store: Reset = 1 with sw 0xFFFFFFFF to 0x40 in the same cycle -> next cycle lw 0x40 SHALL return 0, and all previously written words SHALL read 0.

Source files
------------

// File: rtl/data_mem.sv
// Data memory for the MEM stage: byte-addressed, little-endian word array
// with combinational sub-word loads, byte/halfword/word stores, alignment
// and range checking. Storage is cleared by a synchronous, active-high Reset.
module data_mem #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MemWrite,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  input  logic        MemRead,
  output logic [31:0] DMOut,
  output logic        AddrErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // First byte address past the end of the array; one extra bit so the
  // limit itself never overflows for large depths.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_W    = 2'd0,
    ST_H    = 2'd1,
    ST_B    = 2'd2,
    ST_NONE = 2'd3
  } store_type_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_BU = 3'd1,
    LD_B  = 3'd2,
    LD_HU = 3'd3,
    LD_H  = 3'd4
  } load_type_e;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          out_of_range;
  logic          st_misaligned;
  logic          ld_misaligned;
  logic [3:0]    byte_en;
  logic [31:0]   lane_data;
  logic [31:0]   word_d;
  logic          store_en;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Word index straight from the address bits; the range check below keeps
  // an aliased index from ever being used for an out-of-range address.
  assign word_idx     = Addr[AW+1:2];
  assign rd_word      = mem_q[word_idx];
  assign out_of_range = ({1'b0, Addr} >= ADDR_LIMIT);

  // Alignment of the store and load widths currently requested.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    st_misaligned = 1'b0;
    ld_misaligned = 1'b0;
    case (StoreType)
      ST_W:    st_misaligned = (Addr[1:0] != 2'b00);
      ST_H:    st_misaligned = Addr[0];
      default: st_misaligned = 1'b0;
    endcase
    case (LoadType)
      LD_BU, LD_B: ld_misaligned = 1'b0;
      LD_HU, LD_H: ld_misaligned = Addr[0];
      default:     ld_misaligned = (Addr[1:0] != 2'b00);
    endcase
  end

  // Each request is judged against its own width; an idle port raises nothing.
  assign AddrErr = (MemWrite && (st_misaligned || out_of_range)) ||
                   (MemRead  && (ld_misaligned || out_of_range));

  assign store_en = MemWrite && (StoreType != ST_NONE) && !AddrErr;

  // Byte enables and replicated store data for the requested store width.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = WData;
    case (StoreType)
      ST_W: begin
        byte_en   = 4'b1111;
        lane_data = WData;
      end
      ST_H: begin
        byte_en   = Addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WData[15:0]}};
      end
      ST_B: begin
        byte_en   = 4'b0001 << Addr[1:0];
        lane_data = {4{WData[7:0]}};
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = WData;
      end
    endcase
  end

  // Merge enabled lanes over the current word so partial stores keep the
  // untouched bytes.
  always_comb begin
    word_d = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) word_d[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  // Storage update: Reset wipes every word and wins over a same-cycle store.
  always_ff @(posedge Clock) begin
    // NOTE: the array is reset word by word because software relies on a
    // fully cleared memory after Reset; this rules out mapping to a plain
    // RAM macro, which is accepted for this block.
    if (Reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // reader in this cycle sees the pre-edge contents.
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (store_en) begin
      mem_q[word_idx] <= word_d;
    end
  end

  // Sub-word selection and extension of the load data.
  always_comb begin
    case (Addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = Addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (LoadType)
      LD_BU:   load_ext = {24'h000000, byte_sel};
      LD_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      LD_HU:   load_ext = {16'h0000, half_sel};
      LD_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
  end

  // Faulting or out-of-range accesses never expose array contents.
  assign DMOut = (AddrErr || out_of_range) ? 32'h0000_0000 : load_ext;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: hand-computed expectations for word and
// sub-word paths, alignment and range errors, read-before-write and reset.
module tb_data_mem;

  logic        Clock;
  logic        Reset;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        MemWrite;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic        MemRead;
  logic [31:0] DMOut;
  logic        AddrErr;

  int n_cmp = 0;
  int n_mis = 0;

  data_mem #(.DEPTH_WORDS(1024)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Addr     (Addr),
    .WData    (WData),
    .MemWrite (MemWrite),
    .StoreType(StoreType),
    .LoadType (LoadType),
    .MemRead  (MemRead),
    .DMOut    (DMOut),
    .AddrErr  (AddrErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply a store request and let the combinational outputs settle.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
    Addr = a; WData = d; StoreType = st; MemWrite = 1'b1;
    MemRead = 1'b0; LoadType = 3'd0;
    #1;
  endtask

  // Apply a load request and let the combinational outputs settle.
  task automatic load(input logic [31:0] a, input logic [2:0] lt, input logic rd);
    Addr = a; LoadType = lt; MemRead = rd;
    MemWrite = 1'b0; WData = 32'h0; StoreType = 2'd0;
    #1;
  endtask

  // Clock edge, then step off it before anything is driven or sampled.
  task automatic step();
    @(posedge Clock);
    #1;
    MemWrite = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Addr = 32'h0; WData = 32'h0; MemWrite = 1'b0;
    StoreType = 2'd0; LoadType = 3'd0; MemRead = 1'b0;
    step();
    step();
    Reset = 1'b0;

    // Cleared after reset
    load(32'h10, 3'd0, 1'b1);
    check("rst_lw10", DMOut, 32'h0);
    check("rst_err", {31'b0, AddrErr}, 32'h0);
    load(32'hFFC, 3'd0, 1'b1);
    check("rst_lwFFC", DMOut, 32'h0);

    // Full-word path
    store(32'h10, 32'h8765_4321, 2'd0);
    check("sw10_err", {31'b0, AddrErr}, 32'h0);
    step();
    load(32'h10, 3'd0, 1'b1); check("lw10",   DMOut, 32'h8765_4321);
    load(32'h13, 3'd1, 1'b1); check("lbu13",  DMOut, 32'h0000_0087);
    load(32'h13, 3'd2, 1'b1); check("lb13",   DMOut, 32'hFFFF_FF87);
    load(32'h12, 3'd4, 1'b1); check("lh12",   DMOut, 32'hFFFF_8765);
    load(32'h10, 3'd3, 1'b1); check("lhu10",  DMOut, 32'h0000_4321);
    load(32'h10, 3'd2, 1'b1); check("lb10",   DMOut, 32'h0000_0021);
    load(32'h11, 3'd1, 1'b1); check("lbu11",  DMOut, 32'h0000_0043);
    load(32'h10, 3'd4, 1'b1); check("lh10",   DMOut, 32'h0000_4321);
    load(32'h12, 3'd3, 1'b1); check("lhu12",  DMOut, 32'h0000_8765);
    load(32'h10, 3'd6, 1'b1); check("lt6_lw", DMOut, 32'h8765_4321);

    // Partial stores accumulate on consecutive cycles
    store(32'h21, 32'h1234_56AB, 2'd2); step();
    store(32'h22, 32'h9999_CDEF, 2'd1); step();
    load(32'h20, 3'd0, 1'b1); check("lw20", DMOut, 32'hCDEF_AB00);
    store(32'h24, 32'h0000_0011, 2'd2); step();
    store(32'h25, 32'h0000_0022, 2'd2); step();
    load(32'h24, 3'd0, 1'b1); check("sb_sb24", DMOut, 32'h0000_2211);

    // Misaligned accesses
    store(32'h100, 32'h1111_1111, 2'd0); step();
    store(32'h102, 32'hDEAD_BEEF, 2'd0);
    check("sw102_err", {31'b0, AddrErr}, 32'h1);
    step();
    load(32'h100, 3'd0, 1'b1); check("lw100_keep", DMOut, 32'h1111_1111);
    store(32'h101, 32'h0000_2222, 2'd1);
    check("sh101_err", {31'b0, AddrErr}, 32'h1);
    step();
    load(32'h100, 3'd0, 1'b1); check("lw100_keep2", DMOut, 32'h1111_1111);
    load(32'h105, 3'd4, 1'b1);
    check("lh105_err", {31'b0, AddrErr}, 32'h1);
    check("lh105_out", DMOut, 32'h0);
    load(32'h106, 3'd3, 1'b1);
    check("lhu106_err", {31'b0, AddrErr}, 32'h0);
    load(32'h103, 3'd1, 1'b1);
    check("lbu103", DMOut, 32'h0000_0011);
    store(32'h103, 32'h0000_00A5, 2'd2);
    check("sb103_err", {31'b0, AddrErr}, 32'h0);
    step();
    load(32'h100, 3'd0, 1'b1); check("sb103_word", DMOut, 32'hA511_1111);

    // Out of range, including the aliasing word 0 and the top word
    store(32'h1000, 32'hCAFE_F00D, 2'd0);
    check("sw1000_err", {31'b0, AddrErr}, 32'h1);
    step();
    load(32'h0, 3'd0, 1'b1); check("lw0_keep", DMOut, 32'h0);
    load(32'h1000, 3'd0, 1'b0);
    check("oor_noread_err", {31'b0, AddrErr}, 32'h0);
    check("oor_noread_out", DMOut, 32'h0);
    store(32'hFFC, 32'h0BAD_F00D, 2'd0);
    check("swFFC_err", {31'b0, AddrErr}, 32'h0);
    step();
    load(32'hFFC, 3'd0, 1'b1); check("lwFFC", DMOut, 32'h0BAD_F00D);
    load(32'hFFFF_FFFC, 3'd0, 1'b1);
    check("nowrap_err", {31'b0, AddrErr}, 32'h1);
    check("nowrap_out", DMOut, 32'h0);
    load(32'h0000_2FFC, 3'd0, 1'b1);
    check("alias_out", DMOut, 32'h0);

    // Reserved store type writes nothing
    store(32'h50, 32'hFFFF_FFFF, 2'd3); step();
    load(32'h50, 3'd0, 1'b1); check("st3_none", DMOut, 32'h0);

    // Same-cycle store and load: old data now, new data next cycle
    Addr = 32'h30; WData = 32'h5A5A_5A5A; StoreType = 2'd0; MemWrite = 1'b1;
    LoadType = 3'd0; MemRead = 1'b1;
    #1;
    check("rbw_old", DMOut, 32'h0);
    step();
    #1;
    check("rbw_new", DMOut, 32'h5A5A_5A5A);

    // Reset beats a simultaneous store and clears every prior write
    Reset = 1'b1;
    store(32'h40, 32'hFFFF_FFFF, 2'd0);
    step();
    Reset = 1'b0;
    load(32'h40,  3'd0, 1'b1); check("rst_st40",   DMOut, 32'h0);
    load(32'h10,  3'd0, 1'b1); check("rst_clr10",  DMOut, 32'h0);
    load(32'h20,  3'd0, 1'b1); check("rst_clr20",  DMOut, 32'h0);
    load(32'h100, 3'd0, 1'b1); check("rst_clr100", DMOut, 32'h0);
    load(32'h30,  3'd0, 1'b1); check("rst_clr30",  DMOut, 32'h0);
    load(32'hFFC, 3'd0, 1'b1); check("rst_clrFFC", DMOut, 32'h0);
    load(32'h42,  3'd0, 1'b1);
    check("rst_err_follow", {31'b0, AddrErr}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
